// File: rtl/spatz_l1d_cfg_sequencer.sv
// Breaks L1D maintenance / SPM resize requests into ordered flush and invalidate
// steps, broadcasting each step to every cache controller and collecting completions.
module spatz_l1d_cfg_sequencer #(
    parameter int unsigned         NumCacheCtrl = 4,
    parameter int unsigned         SPMWidth     = 10,
    parameter logic [SPMWidth-1:0] SpmSizeReset = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [SPMWidth-1:0]     req_spm_size_i,
    output logic [1:0]              insn_o,
    output logic [NumCacheCtrl-1:0] insn_valid_o,
    input  logic [NumCacheCtrl-1:0] insn_ready_i,
    input  logic [NumCacheCtrl-1:0] insn_done_i,
    output logic [SPMWidth-1:0]     spm_size_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [31:0]             last_cycles_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, APPLY, FINISH} state_e;

    localparam logic [1:0] OpFlush      = 2'd0;
    localparam logic [1:0] OpInval      = 2'd1;
    localparam logic [1:0] OpFlushInval = 2'd2;
    localparam logic [1:0] OpResize     = 2'd3;

    localparam logic [1:0] InsnFlush = 2'd0;
    localparam logic [1:0] InsnInval = 2'd1;

    state_e                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [1:0]              step_q, step_d;
    logic [SPMWidth-1:0]     size_q, size_d;
    logic [SPMWidth-1:0]     spm_q, spm_d;
    logic [NumCacheCtrl-1:0] accepted_q, accepted_d;
    logic [NumCacheCtrl-1:0] done_q, done_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             last_q, last_d;

    logic [NumCacheCtrl-1:0] acc_seen;
    logic [NumCacheCtrl-1:0] done_seen;
    logic [31:0]             cnt_inc;

    // Step list per operation: index 1 of a RESIZE is the APPLY slot, not a broadcast.
    function automatic logic [1:0] step_insn(input logic [1:0] op, input logic [1:0] idx);
        logic [1:0] insn;
        insn = InsnFlush;
        case (op)
            OpInval:      insn = InsnInval;
            OpFlushInval: insn = (idx == 2'd0) ? InsnFlush : InsnInval;
            OpResize:     insn = (idx == 2'd2) ? InsnInval : InsnFlush;
            default:      insn = InsnFlush;
        endcase
        return insn;
    endfunction

    function automatic logic [1:0] last_step(input logic [1:0] op);
        logic [1:0] idx;
        idx = 2'd0;
        case (op)
            OpFlushInval: idx = 2'd1;
            OpResize:     idx = 2'd2;
            default:      idx = 2'd0;
        endcase
        return idx;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= OpFlush;
            step_q     <= 2'd0;
            size_q     <= '0;
            spm_q      <= SpmSizeReset;
            accepted_q <= '0;
            done_q     <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            step_q     <= step_d;
            size_q     <= size_d;
            spm_q      <= spm_d;
            accepted_q <= accepted_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    // A done pulse only counts once its controller has accepted, possibly in the same cycle.
    assign acc_seen  = (state_q == ISSUE) ? (accepted_q | insn_ready_i) : accepted_q;
    assign done_seen = done_q | (insn_done_i & acc_seen);
    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        step_d     = step_q;
        size_d     = size_q;
        spm_d      = spm_q;
        accepted_d = accepted_q;
        done_d     = done_q;
        cnt_d      = (state_q == IDLE) ? cnt_q : cnt_inc;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d       = req_op_i;
                    size_d     = req_spm_size_i;
                    step_d     = 2'd0;
                    cnt_d      = '0;
                    accepted_d = '0;
                    done_d     = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                accepted_d = acc_seen;
                done_d     = done_seen;
                if (&acc_seen) state_d = WAIT;
            end
            WAIT: begin
                done_d = done_seen;
                if (&done_seen) begin
                    accepted_d = '0;
                    done_d     = '0;
                    if (step_q == last_step(op_q)) begin
                        state_d = FINISH;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = (op_q == OpResize && step_q == 2'd0) ? APPLY : ISSUE;
                    end
                end
            end
            APPLY: begin
                spm_d   = size_q;
                step_d  = step_q + 2'd1;
                state_d = ISSUE;
            end
            FINISH: begin
                last_d  = cnt_inc;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == FINISH);
        insn_valid_o  = (state_q == ISSUE) ? ~accepted_q : '0;
        insn_o        = (state_q == IDLE) ? InsnFlush : step_insn(op_q, step_q);
        spm_size_o    = spm_q;
        last_cycles_o = last_q;
    end

endmodule

// File: tb/tb_spatz_l1d_cfg_sequencer.sv
// Directed self-checking bench for spatz_l1d_cfg_sequencer with four controllers.
module tb_spatz_l1d_cfg_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = 2'd0;
    logic [9:0]  req_spm_size_i = 10'd0;
    logic [1:0]  insn_o;
    logic [3:0]  insn_valid_o;
    logic [3:0]  insn_ready_i = 4'h0;
    logic [3:0]  insn_done_i = 4'h0;
    logic [9:0]  spm_size_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] last_cycles_o;

    int checks = 0;
    int passes = 0;

    spatz_l1d_cfg_sequencer #(
        .NumCacheCtrl(4),
        .SPMWidth    (10),
        .SpmSizeReset(10'h000)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_spm_size_i(req_spm_size_i),
        .insn_o        (insn_o),
        .insn_valid_o  (insn_valid_o),
        .insn_ready_i  (insn_ready_i),
        .insn_done_i   (insn_done_i),
        .spm_size_o    (spm_size_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .last_cycles_o (last_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_ni = 1'b0;
        #2;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rst_busy: got %b want 0", busy_o); else passes++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL rst_done: got %b want 0", done_o); else passes++;
        checks++; if (insn_valid_o !== 4'h0) $display("[TB] FAIL rst_valid: got %h want 0", insn_valid_o); else passes++;
        checks++; if (insn_o !== 2'd0) $display("[TB] FAIL rst_insn: got %0d want 0", insn_o); else passes++;
        checks++; if (spm_size_o !== 10'h000) $display("[TB] FAIL rst_spm: got %h want 000", spm_size_o); else passes++;
        checks++; if (last_cycles_o !== 32'd0) $display("[TB] FAIL rst_last: got %0d want 0", last_cycles_o); else passes++;
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();
        checks++; if (req_ready_o !== 1'b1) $display("[TB] FAIL rst_ready: got %b want 1", req_ready_o); else passes++;
    endtask

    task automatic test_min_flush(input string tag);
        req_valid_i = 1'b1;
        req_op_i    = 2'd0;
        checks++; if (req_ready_o !== 1'b1) $display("[TB] FAIL %s_ready: got %b want 1", tag, req_ready_o); else passes++;
        cyc();
        req_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL %s_busy: got %b want 1", tag, busy_o); else passes++;
        checks++; if (insn_valid_o !== 4'hF) $display("[TB] FAIL %s_valid: got %h want f", tag, insn_valid_o); else passes++;
        insn_ready_i = 4'hF;
        insn_done_i  = 4'hF;
        cyc();
        insn_ready_i = 4'h0;
        insn_done_i  = 4'h0;
        checks++; if (insn_valid_o !== 4'h0) $display("[TB] FAIL %s_wait_valid: got %h want 0", tag, insn_valid_o); else passes++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL %s_early_done: got %b want 0", tag, done_o); else passes++;
        cyc();
        checks++; if (done_o !== 1'b1) $display("[TB] FAIL %s_done: got %b want 1", tag, done_o); else passes++;
        cyc();
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL %s_idle: got %b want 0", tag, busy_o); else passes++;
        checks++; if (last_cycles_o !== 32'd3) $display("[TB] FAIL %s_last: got %0d want 3", tag, last_cycles_o); else passes++;
    endtask

    // Controller i accepts at t+1+i and reports done five cycles later.
    task automatic test_staggered_flush();
        logic [3:0] expValid;
        req_valid_i = 1'b1;
        req_op_i    = 2'd0;
        cyc();
        req_valid_i = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            for (int i = 0; i < 4; i++) expValid[i] = (k <= i + 1);
            checks++; if (insn_valid_o !== expValid) $display("[TB] FAIL stag_valid k=%0d: got %h want %h", k, insn_valid_o, expValid); else passes++;
            checks++; if (insn_o !== 2'd0) $display("[TB] FAIL stag_insn k=%0d: got %0d want 0", k, insn_o); else passes++;
            checks++; if (done_o !== (k == 10)) $display("[TB] FAIL stag_done k=%0d: got %b want %b", k, done_o, (k == 10)); else passes++;
            if (k == 11) begin
                checks++; if (last_cycles_o !== 32'd10) $display("[TB] FAIL stag_last: got %0d want 10", last_cycles_o); else passes++;
                checks++; if (busy_o !== 1'b0) $display("[TB] FAIL stag_idle: got %b want 0", busy_o); else passes++;
            end
            for (int i = 0; i < 4; i++) begin
                insn_ready_i[i] = (k == i + 1);
                insn_done_i[i]  = (k == i + 6);
            end
            cyc();
        end
        insn_ready_i = 4'h0;
        insn_done_i  = 4'h0;
    endtask

    // Flush accepted t+1, done t+3, APPLY t+4, inval issued t+5, done t+7, FINISH t+8.
    task automatic test_resize();
        logic [9:0] expSpm;
        logic [3:0] expValid;
        req_valid_i    = 1'b1;
        req_op_i       = 2'd3;
        req_spm_size_i = 10'h040;
        cyc();
        req_valid_i    = 1'b0;
        req_spm_size_i = 10'h000;
        for (int k = 1; k <= 9; k++) begin
            expSpm   = (k >= 5) ? 10'h040 : 10'h000;
            expValid = (k == 1 || k == 5) ? 4'hF : 4'h0;
            checks++; if (spm_size_o !== expSpm) $display("[TB] FAIL rsz_spm k=%0d: got %h want %h", k, spm_size_o, expSpm); else passes++;
            checks++; if (insn_valid_o !== expValid) $display("[TB] FAIL rsz_valid k=%0d: got %h want %h", k, insn_valid_o, expValid); else passes++;
            checks++; if (done_o !== (k == 8)) $display("[TB] FAIL rsz_done k=%0d: got %b want %b", k, done_o, (k == 8)); else passes++;
            if (k == 1 || k == 5) begin
                checks++; if (insn_o !== ((k == 5) ? 2'd1 : 2'd0)) $display("[TB] FAIL rsz_insn k=%0d: got %0d", k, insn_o); else passes++;
            end
            if (k == 9) begin
                checks++; if (last_cycles_o !== 32'd8) $display("[TB] FAIL rsz_last: got %0d want 8", last_cycles_o); else passes++;
            end
            insn_ready_i = (k == 1 || k == 5) ? 4'hF : 4'h0;
            insn_done_i  = (k == 3 || k == 7) ? 4'hF : 4'h0;
            cyc();
        end
        insn_ready_i = 4'h0;
        insn_done_i  = 4'h0;
    endtask

    // Controller 2 pulses done before accepting; only its later done may finish the step.
    task automatic test_early_done();
        logic [3:0] expValid;
        req_valid_i = 1'b1;
        req_op_i    = 2'd0;
        cyc();
        req_valid_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            expValid = (k == 1) ? 4'hF : ((k == 2) ? 4'b0100 : 4'h0);
            checks++; if (insn_valid_o !== expValid) $display("[TB] FAIL early_valid k=%0d: got %h want %h", k, insn_valid_o, expValid); else passes++;
            checks++; if (busy_o !== (k <= 7)) $display("[TB] FAIL early_busy k=%0d: got %b want %b", k, busy_o, (k <= 7)); else passes++;
            checks++; if (done_o !== (k == 7)) $display("[TB] FAIL early_done k=%0d: got %b want %b", k, done_o, (k == 7)); else passes++;
            if (k == 8) begin
                checks++; if (last_cycles_o !== 32'd7) $display("[TB] FAIL early_last: got %0d want 7", last_cycles_o); else passes++;
            end
            insn_ready_i = (k == 1) ? 4'b1011 : ((k == 2) ? 4'b0100 : 4'h0);
            insn_done_i  = (k == 1) ? 4'b1111 : ((k == 6) ? 4'b0100 : 4'h0);
            cyc();
        end
        insn_ready_i = 4'h0;
        insn_done_i  = 4'h0;
    endtask

    task automatic test_back_to_back();
        logic expReady;
        req_valid_i  = 1'b1;
        req_op_i     = 2'd0;
        insn_ready_i = 4'hF;
        insn_done_i  = 4'hF;
        cyc();
        for (int k = 1; k <= 9; k++) begin
            expReady = (k == 4 || k >= 8);
            checks++; if (req_ready_o !== expReady) $display("[TB] FAIL b2b_ready k=%0d: got %b want %b", k, req_ready_o, expReady); else passes++;
            checks++; if (busy_o !== !expReady) $display("[TB] FAIL b2b_busy k=%0d: got %b want %b", k, busy_o, !expReady); else passes++;
            checks++; if (done_o !== (k == 3 || k == 7)) $display("[TB] FAIL b2b_done k=%0d: got %b want %b", k, done_o, (k == 3 || k == 7)); else passes++;
            if (k == 8) begin
                checks++; if (last_cycles_o !== 32'd3) $display("[TB] FAIL b2b_last: got %0d want 3", last_cycles_o); else passes++;
            end
            if (k == 5) req_valid_i = 1'b0;
            cyc();
        end
        insn_ready_i = 4'h0;
        insn_done_i  = 4'h0;
    endtask

    task automatic test_long_ready();
        req_valid_i = 1'b1;
        req_op_i    = 2'd0;
        cyc();
        req_valid_i = 1'b0;
        for (int k = 1; k <= 104; k++) begin
            if (k == 50 || k == 101) begin
                checks++; if (insn_valid_o !== 4'hF) $display("[TB] FAIL long_valid k=%0d: got %h want f", k, insn_valid_o); else passes++;
            end
            if (k >= 100) begin
                checks++; if (done_o !== (k == 103)) $display("[TB] FAIL long_done k=%0d: got %b want %b", k, done_o, (k == 103)); else passes++;
            end
            if (k == 104) begin
                checks++; if (last_cycles_o !== 32'd103) $display("[TB] FAIL long_last: got %0d want 103", last_cycles_o); else passes++;
            end
            insn_ready_i = (k == 101) ? 4'hF : 4'h0;
            insn_done_i  = (k == 101) ? 4'hF : 4'h0;
            cyc();
        end
        insn_ready_i = 4'h0;
        insn_done_i  = 4'h0;
    endtask

    // Relies on the earlier resize leaving spm_size_o at 0x040.
    task automatic test_reset_mid();
        req_valid_i = 1'b1;
        req_op_i    = 2'd2;
        cyc();
        req_valid_i  = 1'b0;
        insn_ready_i = 4'hF;
        cyc();
        insn_ready_i = 4'h0;
        checks++; if (busy_o !== 1'b1) $display("[TB] FAIL mid_busy: got %b want 1", busy_o); else passes++;
        checks++; if (spm_size_o !== 10'h040) $display("[TB] FAIL mid_spm_pre: got %h want 040", spm_size_o); else passes++;
        cyc();
        #3 rst_ni = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) $display("[TB] FAIL mid_rst_busy: got %b want 0", busy_o); else passes++;
        checks++; if (insn_valid_o !== 4'h0) $display("[TB] FAIL mid_rst_valid: got %h want 0", insn_valid_o); else passes++;
        checks++; if (insn_o !== 2'd0) $display("[TB] FAIL mid_rst_insn: got %0d want 0", insn_o); else passes++;
        checks++; if (done_o !== 1'b0) $display("[TB] FAIL mid_rst_done: got %b want 0", done_o); else passes++;
        checks++; if (spm_size_o !== 10'h000) $display("[TB] FAIL mid_rst_spm: got %h want 000", spm_size_o); else passes++;
        checks++; if (last_cycles_o !== 32'd0) $display("[TB] FAIL mid_rst_last: got %0d want 0", last_cycles_o); else passes++;
        cyc();
        cyc();
        rst_ni = 1'b1;
        cyc();
        test_min_flush("post_rst");
    endtask

    initial begin
        test_reset();
        test_min_flush("min");
        test_staggered_flush();
        test_resize();
        test_early_done();
        test_back_to_back();
        test_long_ready();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spatz_l1d_cfg_sequencer.md
# spatz_l1d_cfg_sequencer

Sequences L1 data-cache maintenance and scratchpad (SPM) resize operations across all cache controllers of a Spatz cluster. Sits between the cluster peripheral register file and the `NumCacheCtrl` L1D cache controllers. It accepts one high-level request at a time and breaks it into ordered FLUSH / INVALIDATE steps. Each step is broadcast with a per-controller valid/ready handshake and per-controller completion tracking. For a resize, the new SPM size is applied only between the flush and the invalidate, so the cache is never repartitioned while dirty.

## Interface
Parameters:
- `NumCacheCtrl`, default 4: number of cache controllers (≥1).
- `SPMWidth`, default 10: width of the SPM size field, in cache lines.
- `SpmSizeReset`, default 0: reset value of `spm_size_o`.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset; asynchronous, active-low.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request accepted when both `req_valid_i` and `req_ready_o` are high.
- `req_op_i`, in, 2: operation. 0 = FLUSH, 1 = INVAL, 2 = FLUSH_INVAL, 3 = RESIZE.
- `req_spm_size_i`, in, SPMWidth: new SPM size. Used only for RESIZE.
- `insn_o`, out, 2: step instruction to the controllers. 2'd0 = flush, 2'd1 = invalidate.
- `insn_valid_o`, out, NumCacheCtrl: per-controller instruction valid.
- `insn_ready_i`, in, NumCacheCtrl: per-controller accept.
- `insn_done_i`, in, NumCacheCtrl: per-controller single-cycle completion pulse.
- `spm_size_o`, out, SPMWidth: SPM size currently in force.
- `busy_o`, out, 1: high whenever the FSM is not IDLE.
- `done_o`, out, 1: single-cycle pulse when a request completes.
- `last_cycles_o`, out, 32: latency of the last completed request, in cycles.

## Operation
- FSM states: IDLE, ISSUE, WAIT, APPLY, FINISH.
- Step lists per operation:
  - FLUSH = [flush].
  - INVAL = [inval].
  - FLUSH_INVAL = [flush, inval].
  - RESIZE = [flush, APPLY, inval].
- IDLE:
  - `req_ready_o` = 1.
  - On handshake, latch `req_op_i` and `req_spm_size_i`, load the step pointer, clear the cycle counter, and go to ISSUE.
- ISSUE:
  - `insn_o` = current step.
  - `insn_valid_o[i]` = ~accepted_q[i].
  - On `insn_ready_i[i]`, set accepted_q[i]. Valid for that controller drops the next cycle.
  - When all bits of accepted_q are set (including acceptances this cycle), go to WAIT.
- done_q tracking (active in ISSUE and WAIT):
  - `insn_done_i[i]` sets done_q[i] only if accepted_q[i] is set, or controller i accepts in the same cycle.
  - A done pulse from a controller that has not accepted is ignored.
- WAIT:
  - When done_q is all ones (including this cycle's pulses), clear accepted_q and done_q.
  - If another step remains, advance to it: go to ISSUE, or to APPLY if the next step is APPLY.
  - Otherwise go to FINISH.
- APPLY: one cycle. Register `spm_size_o` ← latched size, then go to ISSUE for the invalidate step.
- FINISH: one cycle.
  - `done_o` = 1.
  - `last_cycles_o` ← counter value.
  - Go to IDLE.
- Cycle counter:
  - Counts every cycle the FSM is outside IDLE, including FINISH.
  - Saturates at 2^32−1; does not wrap.
- A new request is never accepted while busy; the requester must hold `req_valid_i`.
- Reset values, entered immediately on reset assertion, including mid-operation:
  - State = IDLE; accepted_q, done_q and the counter cleared.
  - `insn_valid_o` = 0, `insn_o` = 0, `busy_o` = 0, `done_o` = 0.
  - `spm_size_o` = SpmSizeReset, `last_cycles_o` = 0.
  - `req_ready_o` = 1 once reset is released.

## Timing
- Handshake at cycle t: `insn_valid_o` all ones at t+1; `busy_o` = 1 at t+1.
- Minimum FLUSH latency, with ready and done arriving in the same cycle at t+1: WAIT at t+2, FINISH at t+3 (`done_o` = 1), IDLE at t+4. `last_cycles_o` = 3.
- RESIZE: new `spm_size_o` becomes visible on the cycle after APPLY, which is the same cycle the inval step's valid is raised.
- All outputs are registered or decoded from state only; there is no combinational path from `insn_ready_i` or `insn_done_i` to any output.

## Test plan
- FLUSH, 4 controllers accepting at staggered cycles t+1..t+4, done pulses 5 cycles later each:
  - Each `insn_valid_o[i]` drops the cycle after its ready.
  - `done_o` pulses once, after the last done.
  - `insn_o` = 0 throughout.
- RESIZE with size 0x040 from `spm_size_o` = 0:
  - `spm_size_o` stays 0 until all flush dones are collected.
  - Then `spm_size_o` = 0x040, followed by an inval broadcast (`insn_o` = 1).
  - `done_o` pulses after all inval dones.
- Done pulse from controller 2 before it accepts is ignored: FSM stays in WAIT until a post-accept done arrives from controller 2.
- Back-to-back requests with `req_valid_i` held high: the second request is accepted only in the IDLE cycle after FINISH. `req_ready_o` = 0 for the entire first request.
- Reset asserted during WAIT of a FLUSH_INVAL:
  - Outputs return to reset values asynchronously; `spm_size_o` = SpmSizeReset.
  - After release, a fresh FLUSH completes normally.
- Minimum-latency FLUSH (all ready and done at t+1): `last_cycles_o` = 3. A controller holding ready low for 100 cycles yields `last_cycles_o` = 103.
